// File: rtl/clock_pkg.sv
// Shared definitions for the time-setting controller: mode encodings,
// default cycle constants and the counter width helper.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_e;

    localparam int ONE_SEC_CYCLES      = 100_000_000;
    localparam int DEF_HOLD_CYCLES     = 50_000_000;
    localparam int DEF_REPEAT_CYCLES   = 10_000_000;
    localparam int DEF_BLINK_CYCLES    = 25_000_000;
    localparam int DEF_TIMEOUT_CYCLES  = 1_000_000_000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared width for every counter, sized for the largest limit
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        return $clog2(max2(max2(a, b), max2(c, d))) + 1;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button level followed by a
// registered rising-edge detector.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic sync_d_r;
    logic rise_r;

    // Synchronizer chain and one-cycle rise pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r   <= 1'b0;
            sync_r   <= 1'b0;
            sync_d_r <= 1'b0;
            rise_r   <= 1'b0;
        end else begin
            meta_r   <= btn;
            sync_r   <= meta_r;
            sync_d_r <= sync_r;
            rise_r   <= sync_r & ~sync_d_r;
        end
    end

    assign level = sync_r;
    assign rise  = rise_r;

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set mode controller for the time-of-day counter: mode FSM, press-and-hold
// auto-repeat, inactivity timeout and display blink strobe.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES  = DEF_REPEAT_CYCLES,
    parameter int BLINK_CYCLES   = DEF_BLINK_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic       en,
    output logic       hrup,
    output logic       minup,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int CW = cnt_width(HOLD_CYCLES, REPEAT_CYCLES, BLINK_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CW-1:0] HOLD_C    = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] REPEAT_C  = CW'(REPEAT_CYCLES);
    localparam logic [CW-1:0] BLINK_C   = CW'(BLINK_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    logic          mode_level_unused_s;
    logic          mode_rise_s;
    logic          up_level_s;
    logic          up_rise_s;

    mode_e         state_r;
    mode_e         state_next;
    logic          in_set_s;
    logic          stay_s;
    logic          inc_s;
    logic          hold_hit_s;
    logic          tmo_hit_s;
    logic [CW-1:0] hold_tgt_s;

    logic [CW-1:0] hold_cnt_r;
    logic          repeat_r;
    logic [CW-1:0] tmo_cnt_r;
    logic [CW-1:0] blink_cnt_r;
    logic          blink_r;
    logic          en_r;
    logic          hrup_r;
    logic          minup_r;

    btn_sync_edge u_mode_sync (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_mode),
        .level (mode_level_unused_s),
        .rise  (mode_rise_s)
    );

    btn_sync_edge u_up_sync (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_up),
        .level (up_level_s),
        .rise  (up_rise_s)
    );

    assign in_set_s   = (state_r != MODE_RUN);
    assign stay_s     = (state_next == state_r);
    assign hold_tgt_s = repeat_r ? REPEAT_C : HOLD_C;
    assign hold_hit_s = up_level_s && (hold_cnt_r == hold_tgt_s);
    assign tmo_hit_s  = (tmo_cnt_r == TIMEOUT_C);

    // Mode state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= MODE_RUN;
        end else begin
            state_r <= state_next;
        end
    end

    // Next state and increment decision; a mode change always beats an increment
    always_comb begin
        state_next = state_r;
        inc_s      = 1'b0;
        case (state_r)
            MODE_RUN: begin
                if (mode_rise_s) begin
                    state_next = MODE_SET_HR;
                end else begin
                    state_next = MODE_RUN;
                end
            end
            MODE_SET_HR: begin
                if (mode_rise_s) begin
                    state_next = MODE_SET_MIN;
                end else if (tmo_hit_s) begin
                    state_next = MODE_RUN;
                end else begin
                    state_next = MODE_SET_HR;
                end
            end
            MODE_SET_MIN: begin
                if (mode_rise_s || tmo_hit_s) begin
                    state_next = MODE_RUN;
                end else begin
                    state_next = MODE_SET_MIN;
                end
            end
            default: begin
                state_next = MODE_RUN;
            end
        endcase
        // Back-to-back pulses are blocked so the counter never sees a 2-cycle strobe
        if (in_set_s && (state_next == state_r) && !(hrup_r || minup_r)) begin
            inc_s = up_rise_s || hold_hit_s;
        end else begin
            inc_s = 1'b0;
        end
    end

    // Hold/repeat counter; the match cycle itself counts, hence the reload to one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r <= '0;
            repeat_r   <= 1'b0;
        end else if (!in_set_s || !stay_s || !up_level_s) begin
            hold_cnt_r <= '0;
            repeat_r   <= 1'b0;
        end else if (up_rise_s) begin
            hold_cnt_r <= CNT_ONE;
            repeat_r   <= 1'b0;
        end else if (hold_hit_s) begin
            hold_cnt_r <= CNT_ONE;
            repeat_r   <= 1'b1;
        end else if (hold_cnt_r != '0) begin
            hold_cnt_r <= hold_cnt_r + CNT_ONE;
            repeat_r   <= repeat_r;
        end else begin
            hold_cnt_r <= hold_cnt_r;
            repeat_r   <= repeat_r;
        end
    end

    // Inactivity timeout counter, restarted by set-state entry and button rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if (!in_set_s || !stay_s) begin
            tmo_cnt_r <= '0;
        end else if (mode_rise_s || up_rise_s || tmo_hit_s) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
        end
    end

    // Blink strobe: lit on entry and on every increment, then toggles each half-period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_r     <= 1'b0;
            blink_cnt_r <= '0;
        end else if (state_next == MODE_RUN) begin
            blink_r     <= 1'b0;
            blink_cnt_r <= '0;
        end else if (!stay_s || inc_s) begin
            blink_r     <= 1'b1;
            blink_cnt_r <= CNT_ONE;
        end else if (blink_cnt_r == BLINK_C) begin
            blink_r     <= ~blink_r;
            blink_cnt_r <= CNT_ONE;
        end else begin
            blink_r     <= blink_r;
            blink_cnt_r <= blink_cnt_r + CNT_ONE;
        end
    end

    // Registered counter controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_r    <= 1'b1;
            hrup_r  <= 1'b0;
            minup_r <= 1'b0;
        end else begin
            en_r    <= (state_next == MODE_RUN);
            hrup_r  <= inc_s && (state_r == MODE_SET_HR);
            minup_r <= inc_s && (state_r == MODE_SET_MIN);
        end
    end

    assign en    = en_r;
    assign hrup  = hrup_r;
    assign minup = minup_r;
    assign mode  = state_r;
    assign blink = blink_r;

endmodule
